// File: rtl/ls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ls_pkg
//  Description : Shared definitions for the least-squares moment accumulator:
//                FSM encoding, default Q-format constants, counter-width and
//                flat-bus lane helpers.
//  Ports       : (package, no ports)
//  Revision    : 1.0  initial release
// ============================================================================
package ls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Bit offset of lane k on a flat bus of w-bit lanes.
    function automatic int lane_off(input int k, input int w);
        return k * w;
    endfunction

    // Number of sum(x^k) lanes for a given polynomial degree.
    function automatic int sx_lanes(input int deg);
        return 2 * deg + 1;
    endfunction

    localparam int LS_IN_W  = 12;
    localparam int LS_FRAC  = 4;
    localparam int LS_DEG   = 2;
    localparam int LS_N     = 256;
    // Wide enough for N copies of the largest term x^(2*DEG).
    localparam int LS_ACC_W = 2 * LS_DEG * LS_IN_W + clog2(LS_N) + 1;

endpackage
`default_nettype wire

// File: rtl/ls_power_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ls_power_stage
//  Description : First pipeline stage. Registers x^k (k=1..2*DEG) and
//                x^k*y (k=0..DEG) for an accepted sample, with a valid bit.
//                Every term is carried in a 2*DEG*IN_W-bit slot, which holds
//                the largest product exactly.
//  Ports       : clk, rst_n      clock, async active-low reset
//                flush          clears the valid bit (abort)
//                in_valid       sample accepted this cycle
//                x_in, y_in     sample pair
//                out_valid      registered terms are valid
//                xp             x^k, k=1..2*DEG
//                xyp            x^k*y, k=0..DEG
//  Revision    : 1.0  initial release
// ============================================================================
module ls_power_stage
    import ls_pkg::*;
#(
    parameter int DEG  = LS_DEG,
    parameter int IN_W = LS_IN_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic [IN_W-1:0]                   x_in,
    input  logic [IN_W-1:0]                   y_in,
    output logic                              out_valid,
    output logic [2*DEG:1][2*DEG*IN_W-1:0]    xp,
    output logic [DEG:0][2*DEG*IN_W-1:0]      xyp
);

    localparam int TW = 2 * DEG * IN_W;

    logic [TW-1:0]              w_x_ext;
    logic [TW-1:0]              w_y_ext;
    logic [2*DEG:0][TW-1:0]     w_pow;
    logic [DEG:0][TW-1:0]       w_xy;

    assign w_x_ext = TW'(x_in);
    assign w_y_ext = TW'(y_in);

    // Power chain; every partial product fits in TW bits, so no bits are lost.
    always_comb begin
        w_pow    = '0;
        w_xy     = '0;
        w_pow[0] = TW'(1);
        for (int k = 1; k <= 2 * DEG; k++) begin
            w_pow[k] = w_pow[k-1] * w_x_ext;
        end
        for (int k = 0; k <= DEG; k++) begin
            w_xy[k] = w_pow[k] * w_y_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            xp        <= '0;
            xyp       <= '0;
        end else begin
            out_valid <= in_valid && !flush;
            if (in_valid) begin
                xp  <= w_pow[2*DEG:1];
                xyp <= w_xy;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ls_moment_acc.sv
`default_nettype none
// ============================================================================
//  Module      : ls_moment_acc
//  Description : Streams N (x, y) pairs and accumulates sum(x^k), k=0..2*DEG,
//                and sum(x^k*y), k=0..DEG, for the least-squares normal
//                equations. Input/output valid-ready handshakes, abort and a
//                sticky overflow flag.
//  Ports       : clk, rst_n              clock, async active-low reset
//                start, abort            batch start (IDLE only), cancel
//                in_valid/in_ready       sample handshake, x_in, y_in
//                out_valid/out_ready     result handshake
//                sx_flat, sxy_flat       lane k at [k*ACC_W +: ACC_W]
//                ovf, busy               sticky overflow, state != IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module ls_moment_acc
    import ls_pkg::*;
#(
    parameter int IN_W  = LS_IN_W,
    parameter int FRAC  = LS_FRAC,
    parameter int DEG   = LS_DEG,
    parameter int N     = LS_N,
    parameter int ACC_W = LS_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          x_in,
    input  logic [IN_W-1:0]          y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(2*DEG+1)*ACC_W-1:0] sx_flat,
    output logic [(DEG+1)*ACC_W-1:0]   sxy_flat,
    output logic                     ovf,
    output logic                     busy
);

    localparam int TW   = 2 * DEG * IN_W;
    localparam int EW   = (TW > ACC_W) ? TW : ACC_W;
    localparam int CW   = clog2(N + 1);
    localparam int NSX  = sx_lanes(DEG);
    localparam int NL   = NSX + DEG + 1;

    // Lanes keep each term's native fraction (FRAC*k); no alignment happens
    // here, so FRAC only qualifies the format. A fraction wider than the word
    // has no meaning and leaves this branch elaborated as a marker.
    if (FRAC > IN_W) begin : g_frac_wider_than_word
    end

    state_t                  r_state;
    logic [CW-1:0]           r_count;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_ovf;
    logic                    r_acc_v;
    logic [NL-1:0][ACC_W-1:0] r_lane;

    logic                        w_accept;
    logic                        w_pv;
    logic [2*DEG:1][TW-1:0]      w_xp;
    logic [DEG:0][TW-1:0]        w_xyp;
    logic [NL-1:0][TW-1:0]       w_term;
    logic [NL-1:0][ACC_W-1:0]    w_lane_nxt;
    logic                        w_lane_ovf;
    logic [EW-1:0]               w_t_ext;
    logic [ACC_W:0]              w_sum;

    assign w_accept = in_valid && r_in_ready && !abort;

    ls_power_stage #(
        .DEG  (DEG),
        .IN_W (IN_W)
    ) u_power (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (w_accept),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (w_pv),
        .xp        (w_xp),
        .xyp       (w_xyp)
    );

    // Lane 0 counts samples, lanes 1..2*DEG take x^k, the rest take x^k*y.
    assign w_term = {w_xyp, w_xp, TW'(1)};

    // Zero-extend (or truncate) each term into its lane; flag lost MSBs and
    // carries out of the lane.
    always_comb begin
        w_lane_nxt = r_lane;
        w_lane_ovf = 1'b0;
        w_t_ext    = '0;
        w_sum      = '0;
        for (int k = 0; k < NL; k++) begin
            w_t_ext       = EW'(w_term[k]);
            w_sum         = {1'b0, r_lane[k]} + {1'b0, w_t_ext[ACC_W-1:0]};
            w_lane_nxt[k] = w_sum[ACC_W-1:0];
            w_lane_ovf    = w_lane_ovf | w_sum[ACC_W] | (|(w_t_ext >> ACC_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_acc_v     <= 1'b0;
            r_lane      <= '0;
        end else if (abort) begin
            // Lanes and ovf keep their partial values until the next start.
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc_v     <= 1'b0;
        end else begin
            if (w_pv) begin
                r_lane <= w_lane_nxt;
                r_ovf  <= r_ovf | w_lane_ovf;
            end
            // Second valid bit: set in the cycle the last term lands in a lane.
            r_acc_v <= w_pv;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_ACC;
                        r_lane     <= '0;
                        r_ovf      <= 1'b0;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_count <= r_count + CW'(1);
                        if (r_count == CW'(N - 1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_pv && !r_acc_v) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign busy      = (r_state != ST_IDLE);
    assign sx_flat   = r_lane[NSX-1:0];
    assign sxy_flat  = r_lane[NL-1:NSX];

endmodule
`default_nettype wire

// File: tb/tb_ls_moment_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls_moment_acc
//  Description : Self-checking bench. Two instances share all inputs: one
//                with wide lanes (no overflow possible) and one with 20-bit
//                lanes (overflow reachable). Expected sums come from an
//                arithmetic model over the accepted-sample list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ls_moment_acc;
    import ls_pkg::*;

    localparam int IN_W    = 12;
    localparam int FRAC    = 4;
    localparam int DEG     = 2;
    localparam int N       = 4;
    localparam int ACC_W   = 57;
    localparam int ACC_W_S = 20;
    localparam int NSX     = 2 * DEG + 1;
    localparam int NSXY    = DEG + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [IN_W-1:0] x_in = '0;
    logic [IN_W-1:0] y_in = '0;

    logic in_ready, out_valid, ovf, busy;
    logic [NSX*ACC_W-1:0]  sx_flat;
    logic [NSXY*ACC_W-1:0] sxy_flat;
    logic in_ready_s, out_valid_s, ovf_s, busy_s;
    logic [NSX*ACC_W_S-1:0]  sx_flat_s;
    logic [NSXY*ACC_W_S-1:0] sxy_flat_s;

    int errors = 0;
    int checks = 0;

    longint unsigned q_x[$];
    longint unsigned q_y[$];
    longint unsigned e_sx[NSX];
    longint unsigned e_sxy[NSXY];
    longint unsigned e_sx_s[NSX];
    longint unsigned e_sxy_s[NSXY];
    bit e_ovf, e_ovf_s;

    always #5 clk = ~clk;

    ls_moment_acc #(.IN_W(IN_W), .FRAC(FRAC), .DEG(DEG), .N(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sx_flat(sx_flat), .sxy_flat(sxy_flat), .ovf(ovf), .busy(busy)
    );

    ls_moment_acc #(.IN_W(IN_W), .FRAC(FRAC), .DEG(DEG), .N(N), .ACC_W(ACC_W_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_s), .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .sx_flat(sx_flat_s), .sxy_flat(sxy_flat_s), .ovf(ovf_s), .busy(busy_s)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic longint unsigned ipow(input longint unsigned b, input int e);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Modular lane addition of width w; lost reports truncated MSBs or carry.
    function automatic longint unsigned wrap_add(input longint unsigned acc,
                                                 input longint unsigned term,
                                                 input int w, output bit lost);
        longint unsigned mask, sum;
        mask = (64'd1 << w) - 64'd1;
        lost = (term > mask);
        sum  = acc + (term & mask);
        if (sum > mask) lost = 1'b1;
        return sum & mask;
    endfunction

    task automatic model_sums();
        longint unsigned t;
        bit l;
        e_ovf = 1'b0;
        e_ovf_s = 1'b0;
        for (int k = 0; k < NSX; k++) begin e_sx[k] = 0; e_sx_s[k] = 0; end
        for (int k = 0; k < NSXY; k++) begin e_sxy[k] = 0; e_sxy_s[k] = 0; end
        for (int i = 0; i < q_x.size(); i++) begin
            for (int k = 0; k < NSX; k++) begin
                t = ipow(q_x[i], k);
                e_sx[k]   = wrap_add(e_sx[k], t, ACC_W, l);   e_ovf   = e_ovf | l;
                e_sx_s[k] = wrap_add(e_sx_s[k], t, ACC_W_S, l); e_ovf_s = e_ovf_s | l;
            end
            for (int k = 0; k < NSXY; k++) begin
                t = ipow(q_x[i], k) * q_y[i];
                e_sxy[k]   = wrap_add(e_sxy[k], t, ACC_W, l);   e_ovf   = e_ovf | l;
                e_sxy_s[k] = wrap_add(e_sxy_s[k], t, ACC_W_S, l); e_ovf_s = e_ovf_s | l;
            end
        end
    endtask

    task automatic check_lanes(input string tag);
        model_sums();
        for (int k = 0; k < NSX; k++) begin
            check_val($sformatf("%s sx[%0d]", tag, k), 64'(sx_flat[k*ACC_W +: ACC_W]), e_sx[k]);
            check_val($sformatf("%s sx_s[%0d]", tag, k), 64'(sx_flat_s[k*ACC_W_S +: ACC_W_S]), e_sx_s[k]);
        end
        for (int k = 0; k < NSXY; k++) begin
            check_val($sformatf("%s sxy[%0d]", tag, k), 64'(sxy_flat[k*ACC_W +: ACC_W]), e_sxy[k]);
            check_val($sformatf("%s sxy_s[%0d]", tag, k), 64'(sxy_flat_s[k*ACC_W_S +: ACC_W_S]), e_sxy_s[k]);
        end
        check_val({tag, " ovf"}, 64'(ovf), 64'(e_ovf));
        check_val({tag, " ovf_s"}, 64'(ovf_s), 64'(e_ovf_s));
    endtask

    task automatic do_start();
        q_x.delete();
        q_y.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start busy", 64'(busy), 64'(1));
        check_val("start in_ready", 64'(in_ready), 64'(1));
        check_lanes("start");
    endtask

    // mode 0: back-to-back, 1: fixed gap pattern, 2: random gaps.
    // rnd selects random data instead of fx/fy.
    task automatic feed(input int mode, input bit rnd, input logic [IN_W-1:0] fx,
                        input logic [IN_W-1:0] fy, input int count);
        int acc;
        int cyc;
        bit v;
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        acc = 0;
        cyc = 0;
        while (acc < count && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc < 7) ? pat[cyc] : 1'b1;
                default: v = ($urandom_range(99) < 60);
            endcase
            in_valid = v;
            x_in = (rnd || !v) ? IN_W'($urandom) : fx;
            y_in = (rnd || !v) ? IN_W'($urandom) : fy;
            check_val("acc in_ready", 64'(in_ready), 64'(1));
            tick();
            if (v) begin
                acc++;
                q_x.push_back(64'(x_in));
                q_y.push_back(64'(y_in));
            end
            cyc++;
        end
        in_valid = 1'b0;
        if (acc < count) check_val("feed timeout", 64'(acc), 64'(count));
    endtask

    task automatic expect_done();
        check_val("drain in_ready", 64'(in_ready), 64'(0));
        check_val("drain busy", 64'(busy), 64'(1));
        tick();
        check_val("lat+1 out_valid", 64'(out_valid), 64'(0));
        tick();
        check_val("lat+2 out_valid", 64'(out_valid), 64'(0));
        tick();
        check_val("lat+3 out_valid", 64'(out_valid), 64'(1));
        check_val("lat+3 out_valid_s", 64'(out_valid_s), 64'(1));
        check_lanes("done");
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("release out_valid", 64'(out_valid), 64'(0));
        check_val("release busy", 64'(busy), 64'(0));
        check_val("release busy_s", 64'(busy_s), 64'(0));
    endtask

    initial begin
        // Reset state
        tick();
        check_val("rst in_ready", 64'(in_ready), 64'(0));
        check_val("rst out_valid", 64'(out_valid), 64'(0));
        check_val("rst busy", 64'(busy), 64'(0));
        check_lanes("rst");
        rst_n = 1'b1;
        tick();

        // 1: back-to-back x=1.0, y=2.0
        do_start();
        feed(0, 1'b0, 12'h010, 12'h020, N);
        expect_done();
        check_val("s1 sx0", 64'(sx_flat[0 +: ACC_W]), 64'd4);
        check_val("s1 sx4", 64'(sx_flat[4*ACC_W +: ACC_W]), 64'h40000);
        check_val("s1 sxy2", 64'(sxy_flat[2*ACC_W +: ACC_W]), 64'h8000);
        release_out();

        // 2 + 3: gapped input, then held in DONE with an ignored start
        do_start();
        feed(1, 1'b0, 12'h020, 12'h010, N);
        expect_done();
        check_val("s2 sx1", 64'(sx_flat[1*ACC_W +: ACC_W]), 64'h80);
        check_val("s2 sx2", 64'(sx_flat[2*ACC_W +: ACC_W]), 64'h1000);
        check_val("s2 sxy0", 64'(sxy_flat[0 +: ACC_W]), 64'h40);
        check_val("s2 sxy1", 64'(sxy_flat[1*ACC_W +: ACC_W]), 64'h800);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            start = 1'b0;
            check_val("hold out_valid", 64'(out_valid), 64'(1));
            check_lanes("hold");
        end
        release_out();

        // 4: abort after 2 of 4 samples, then a full batch
        do_start();
        feed(0, 1'b0, 12'h010, 12'h020, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort busy", 64'(busy), 64'(0));
        check_val("abort in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 6; i++) begin
            check_val("abort out_valid", 64'(out_valid), 64'(0));
            tick();
        end
        do_start();
        feed(0, 1'b0, 12'h010, 12'h020, N);
        expect_done();
        check_val("s4 sx4", 64'(sx_flat[4*ACC_W +: ACC_W]), 64'h40000);
        release_out();

        // 5: x=0xFFF overflows the 20-bit lanes only
        do_start();
        feed(2, 1'b0, 12'hFFF, 12'h7A5, N);
        expect_done();
        check_val("s5 ovf_s", 64'(ovf_s), 64'(1));
        check_val("s5 ovf", 64'(ovf), 64'(0));
        tick();
        check_val("s5 ovf_s held", 64'(ovf_s), 64'(1));
        release_out();
        do_start();
        check_val("s5 ovf_s cleared", 64'(ovf_s), 64'(0));
        feed(0, 1'b1, 12'h0, 12'h0, N);
        expect_done();
        release_out();

        // 6: reset in the middle of DRAIN
        do_start();
        feed(0, 1'b1, 12'h0, 12'h0, N);
        tick();
        rst_n = 1'b0;
        #1;
        q_x.delete();
        q_y.delete();
        check_val("mrst out_valid", 64'(out_valid), 64'(0));
        check_val("mrst busy", 64'(busy), 64'(0));
        check_val("mrst in_ready", 64'(in_ready), 64'(0));
        check_lanes("mrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start();
        feed(2, 1'b1, 12'h0, 12'h0, N);
        expect_done();
        release_out();

        // Random batches; out_ready held high outside DONE in some of them
        for (int b = 0; b < 4; b++) begin
            out_ready = b[0];
            do_start();
            feed(2, 1'b1, 12'h0, 12'h0, N);
            expect_done();
            release_out();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
